// File: rtl/phase_pair_fetch_if.sv
// Stream bundle for phase_pair_fetch: input sample stream and output pair stream.
// The slave modport is the fetcher's view; master is the surrounding logic's view.
interface phase_pair_fetch_if #(
    parameter int unsigned PHASE_DW = 15,
    parameter int unsigned FBIT     = 8,
    parameter int unsigned PASS_DW  = 8
);
    logic [PHASE_DW-1:0] in_phase;
    logic [PASS_DW-1:0]  in_pass_data;
    logic                in_last;
    logic                in_valid;
    logic                in_ready;

    logic [PHASE_DW-1:0] phase1;
    logic [PHASE_DW-1:0] phase2;
    logic [FBIT-1:0]     phase_frac;
    logic [PASS_DW-1:0]  phase_pass_data;
    logic                phase_last;
    logic                phase_valid;
    logic                phase_ready;

    modport master (
        output in_phase, in_pass_data, in_last, in_valid,
        input  in_ready,
        input  phase1, phase2, phase_frac, phase_pass_data, phase_last, phase_valid,
        output phase_ready
    );

    modport slave (
        input  in_phase, in_pass_data, in_last, in_valid,
        output in_ready,
        output phase1, phase2, phase_frac, phase_pass_data, phase_last, phase_valid,
        input  phase_ready
    );
endinterface

// File: rtl/phase_pair_fetch.sv
// Feeds the phase interpolator: turns one line of phase samples into (s0, s1, frac)
// triples at a fixed-point output step of at most 1.0 sample per output.
module phase_pair_fetch #(
    parameter int unsigned PHASE_DW = 15,
    parameter int unsigned FBIT     = 8,
    parameter int unsigned PASS_DW  = 8,
    parameter int unsigned CNT_W    = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [FBIT:0]        cfg_step,
    phase_pair_fetch_if.slave    bus,
    output logic [CNT_W-1:0]     out_cnt
);

    typedef enum logic [1:0] {StIdle, StFill, StEmit, StAdv} state_e;

    localparam logic [FBIT:0] StepOne = {1'b1, {FBIT{1'b0}}};

    state_e              state;
    logic [PHASE_DW-1:0] s0, s1;
    logic [PASS_DW-1:0]  s0_pass, s1_pass;
    logic                s1_last;
    logic [FBIT-1:0]     frac;
    logic [FBIT:0]       step_q;
    logic                in_ready_q;
    logic                valid_q;

    logic [FBIT:0]       sum;
    logic                carry;
    logic                in_xfer;
    logic                out_xfer;

    assign sum      = {1'b0, frac} + step_q;
    assign carry    = sum[FBIT];
    assign in_xfer  = bus.in_valid && in_ready_q;
    assign out_xfer = valid_q && bus.phase_ready;

    assign bus.in_ready        = in_ready_q;
    assign bus.phase_valid     = valid_q;
    assign bus.phase1          = s0;
    assign bus.phase2          = s1;
    assign bus.phase_frac      = frac;
    assign bus.phase_pass_data = s0_pass;
    // A carry on the line's last pair means the next position would need a sample beyond it.
    assign bus.phase_last      = valid_q && s1_last && carry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= StIdle;
            s0         <= '0;
            s1         <= '0;
            s0_pass    <= '0;
            s1_pass    <= '0;
            s1_last    <= 1'b0;
            frac       <= '0;
            step_q     <= '0;
            in_ready_q <= 1'b0;
            valid_q    <= 1'b0;
            out_cnt    <= '0;
        end else begin
            case (state)
                StIdle: begin
                    in_ready_q <= 1'b1;
                    if (in_xfer) begin
                        s0      <= bus.in_phase;
                        s0_pass <= bus.in_pass_data;
                        frac    <= '0;
                        out_cnt <= '0;
                        step_q  <= (cfg_step == '0) ? StepOne : cfg_step;
                        // A one-sample line has no pair to bracket, so it is dropped.
                        if (!bus.in_last) state <= StFill;
                    end
                end
                StFill: begin
                    if (in_xfer) begin
                        s1         <= bus.in_phase;
                        s1_pass    <= bus.in_pass_data;
                        s1_last    <= bus.in_last;
                        in_ready_q <= 1'b0;
                        valid_q    <= 1'b1;
                        state      <= StEmit;
                    end
                end
                StEmit: begin
                    if (out_xfer) begin
                        frac    <= sum[FBIT-1:0];
                        out_cnt <= out_cnt + CNT_W'(1);
                        if (carry) begin
                            valid_q    <= 1'b0;
                            in_ready_q <= 1'b1;
                            state      <= s1_last ? StIdle : StAdv;
                        end
                    end
                end
                StAdv: begin
                    if (in_xfer) begin
                        s0         <= s1;
                        s0_pass    <= s1_pass;
                        s1         <= bus.in_phase;
                        s1_pass    <= bus.in_pass_data;
                        s1_last    <= bus.in_last;
                        in_ready_q <= 1'b0;
                        valid_q    <= 1'b1;
                        state      <= StEmit;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
